// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   hz_state_e  : hazard FSM state (RUN / MEM_WAIT)
//   REG_X0      : architectural zero register, never a real dependency
//   hz_ctrl_t   : per-stage stall/flush/bubble controls as seen by the
//                 pipeline registers, plus the canned control patterns
//   src_hit     : helper deciding whether a read operand matches a writer
package hazard_unit_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Bit order matches the pipeline-register enable/clear bundle.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic bubble_wb;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE     = '0;
    // Whole front end frozen behind MEM, WB receives a NOP each cycle.
    localparam hz_ctrl_t CTRL_FREEZE   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    // Taken branch: discard the two younger instructions.
    localparam hz_ctrl_t CTRL_BRANCH   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Load-use: hold PC and IF/ID, push one bubble into ID/EX.
    localparam hz_ctrl_t CTRL_LOAD_USE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    function automatic logic src_hit(input logic rd_en,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
        return rd_en && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle between the pipeline and the hazard unit.
//   ID/EX/MEM status : register addresses, use flags, load/store/branch info,
//                      data-memory request and ready
//   controls         : stall_IF/ID/EX/MEM, flush_ID/EX, bubble_WB
//   status           : mem_timeout (sticky), stall_count (CNT_W bits)
// master = pipeline side, slave = hazard unit.
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       raddr1_ID;
    logic [4:0]       raddr2_ID;
    logic             RS1Use_ID;
    logic             RS2Use_ID;
    logic             MemWrite_ID;
    logic [4:0]       waddr_EX;
    logic             RegWrite_EX;
    logic             MemRead_EX;
    logic             branch_taken_EX;
    logic             mem_req_MEM;
    logic             mem_ready;

    logic             stall_IF;
    logic             stall_ID;
    logic             stall_EX;
    logic             stall_MEM;
    logic             flush_ID;
    logic             flush_EX;
    logic             bubble_WB;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output raddr1_ID, raddr2_ID, RS1Use_ID, RS2Use_ID, MemWrite_ID,
               waddr_EX, RegWrite_EX, MemRead_EX, branch_taken_EX,
               mem_req_MEM, mem_ready,
        input  stall_IF, stall_ID, stall_EX, stall_MEM,
               flush_ID, flush_EX, bubble_WB, mem_timeout, stall_count
    );

    modport slave (
        input  raddr1_ID, raddr2_ID, RS1Use_ID, RS2Use_ID, MemWrite_ID,
               waddr_EX, RegWrite_EX, MemRead_EX, branch_taken_EX,
               mem_req_MEM, mem_ready,
        output stall_IF, stall_ID, stall_EX, stall_MEM,
               flush_ID, flush_EX, bubble_WB, mem_timeout, stall_count
    );

endinterface

// File: rtl/hazard_unit_wait_timer.sv
// hazard_wait_timer: memory-wait bookkeeping for the hazard unit.
//   clk, rst_n      : clock, synchronous active-low reset
//   freeze_start    : first frozen cycle (RUN -> MEM_WAIT)
//   freeze_hold     : further frozen cycle while in MEM_WAIT
//   freeze_release  : memory completed in MEM_WAIT
//   stall           : stall_IF is asserted this cycle
//   mem_timeout     : sticky, set once the wait reaches TIMEOUT_CYCLES
//   stall_count     : wrapping count of stall_IF cycles
module hazard_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze_start,
    input  logic             freeze_hold,
    input  logic             freeze_release,
    input  logic             stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                WCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_CYCLES);

    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_next;

    // wait_cnt equals the number of frozen cycles completed so far,
    // saturating at the timeout threshold.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (freeze_start) begin
            wait_cnt_next = WCNT_W'(1);
        end else if (freeze_hold) begin
            if (wait_cnt != WCNT_MAX) begin
                wait_cnt_next = wait_cnt + WCNT_W'(1);
            end
        end else if (freeze_release) begin
            wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
            // Flag rises on the same edge the count reaches the threshold.
            if ((freeze_start || freeze_hold) && (wait_cnt_next == WCNT_MAX)) begin
                mem_timeout <= 1'b1;
            end
            if (stall) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: detects hazards forwarding cannot cover (load-use, taken
// branch, data-memory wait) and drives the pipeline stall/flush controls.
//   clk, rst_n : clock, synchronous active-low reset
//   hz         : hazard bundle (slave side); stage status in, per-stage
//                controls, mem_timeout and stall_count out
// Controls are Mealy outputs of the wait FSM and are forced low in reset.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);

    hz_state_e state;
    hz_state_e state_next;
    hz_ctrl_t  ctrl;
    hz_ctrl_t  ctrl_out;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mem_freeze;
    logic freeze_start;
    logic freeze_hold;
    logic freeze_release;

    // A store's data operand (rs2) is forwarded at MEM, so it never stalls.
    assign rs1_hit  = src_hit(hz.RS1Use_ID, hz.raddr1_ID, hz.waddr_EX);
    assign rs2_hit  = src_hit(hz.RS2Use_ID, hz.raddr2_ID, hz.waddr_EX) && !hz.MemWrite_ID;
    assign load_use = hz.RegWrite_EX && hz.MemRead_EX && (hz.waddr_EX != REG_X0)
                      && (rs1_hit || rs2_hit);

    assign mem_freeze = hz.mem_req_MEM && !hz.mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        ctrl           = CTRL_NONE;
        freeze_start   = 1'b0;
        freeze_hold    = 1'b0;
        freeze_release = 1'b0;
        case (state)
            RUN: begin
                if (mem_freeze) begin
                    ctrl         = CTRL_FREEZE;
                    state_next   = MEM_WAIT;
                    freeze_start = 1'b1;
                end else if (hz.branch_taken_EX) begin
                    // Branch wins: the dependent instruction is discarded anyway.
                    ctrl = CTRL_BRANCH;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    ctrl        = CTRL_FREEZE;
                    freeze_hold = 1'b1;
                end else begin
                    // Release cycle behaves like RUN without a new freeze; a
                    // branch held in EX during the wait is flushed here.
                    state_next     = RUN;
                    freeze_release = 1'b1;
                    if (hz.branch_taken_EX) begin
                        ctrl = CTRL_BRANCH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
            end
        endcase
    end

    assign ctrl_out = rst_n ? ctrl : CTRL_NONE;

    assign hz.stall_IF  = ctrl_out.stall_if;
    assign hz.stall_ID  = ctrl_out.stall_id;
    assign hz.stall_EX  = ctrl_out.stall_ex;
    assign hz.stall_MEM = ctrl_out.stall_mem;
    assign hz.flush_ID  = ctrl_out.flush_id;
    assign hz.flush_EX  = ctrl_out.flush_ex;
    assign hz.bubble_WB = ctrl_out.bubble_wb;

    hazard_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wait_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .freeze_start  (freeze_start),
        .freeze_hold   (freeze_hold),
        .freeze_release(freeze_release),
        .stall         (ctrl_out.stall_if),
        .mem_timeout   (hz.mem_timeout),
        .stall_count   (hz.stall_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed vector table, hand-written multi-cycle
// sequences (load-use, memory wait, timeout, reset mid-wait) and a randomized
// run checked against a cycle-level reference model of the hazard rules.
module tb_hazard_unit;

    localparam int TO = 64;

    // Control vector order: {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, bubble_WB}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_FRZ  = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(32)) hz();

    hazard_unit #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    wire [6:0] ctrl_act = {hz.stall_IF, hz.stall_ID, hz.stall_EX, hz.stall_MEM,
                           hz.flush_ID, hz.flush_EX, hz.bubble_WB};

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic mw,
                          input logic [4:0] wd, input logic rw, input logic mr,
                          input logic br, input logic req, input logic rdy);
        hz.raddr1_ID       = r1;
        hz.raddr2_ID       = r2;
        hz.RS1Use_ID       = u1;
        hz.RS2Use_ID       = u2;
        hz.MemWrite_ID     = mw;
        hz.waddr_EX        = wd;
        hz.RegWrite_EX     = rw;
        hz.MemRead_EX      = mr;
        hz.branch_taken_EX = br;
        hz.mem_req_MEM     = req;
        hz.mem_ready       = rdy;
    endtask

    task automatic clear_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- reference model ----------------
    bit      m_wait;
    int      m_cycles;
    bit      m_to;
    bit [31:0] m_cnt;

    function automatic bit model_freeze();
        if (m_wait) return !hz.mem_ready;
        return hz.mem_req_MEM && !hz.mem_ready;
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit hit1, hit2, lu;
        if (!rst_n) return C_NONE;
        hit1 = hz.RS1Use_ID && (hz.raddr1_ID == hz.waddr_EX);
        hit2 = hz.RS2Use_ID && (hz.raddr2_ID == hz.waddr_EX) && !hz.MemWrite_ID;
        lu   = hz.RegWrite_EX && hz.MemRead_EX && (hz.waddr_EX != 5'd0) && (hit1 || hit2);
        if (model_freeze())     return C_FRZ;
        if (hz.branch_taken_EX) return C_BR;
        if (lu)                 return C_LU;
        return C_NONE;
    endfunction

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        logic [6:0] c;
        bit f;
        c = model_ctrl();
        f = model_freeze();
        if (!rst_n) begin
            m_wait = 0; m_cycles = 0; m_to = 0; m_cnt = '0;
        end else begin
            if (c[6]) m_cnt = m_cnt + 32'd1;
            if (f) begin
                m_wait = 1;
                m_cycles++;
                if (m_cycles >= TO) m_to = 1;
            end else begin
                m_wait = 0;
                m_cycles = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        cyc();
        rst_n = 1'b1;
        m_wait = 0; m_cycles = 0; m_to = 0; m_cnt = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [4:0] r1, r2;
        logic       u1, u2, mw;
        logic [4:0] wd;
        logic       rw, mr, br, req, rdy;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [4:0] r1, input logic [4:0] r2,
                                input logic u1, input logic u2, input logic mw,
                                input logic [4:0] wd, input logic rw, input logic mr,
                                input logic br, input logic req, input logic rdy,
                                input logic [6:0] exp);
        vec_t v;
        v.name = n; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2; v.mw = mw;
        v.wd = wd; v.rw = rw; v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
        v.exp = exp;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        logic [31:0] exp_cnt;
        int slow;

        tbl[0]  = mk("lu_rs1",         5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 1, 0, 0, 1, C_LU);
        tbl[1]  = mk("store_rs2_exempt", 5'd1, 5'd5, 0, 1, 1, 5'd5, 1, 1, 0, 0, 1, C_NONE);
        tbl[2]  = mk("store_rs1_stall", 5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 1, 0, 0, 1, C_LU);
        tbl[3]  = mk("lu_rs2",         5'd2, 5'd9, 1, 1, 0, 5'd9, 1, 1, 0, 0, 1, C_LU);
        tbl[4]  = mk("x0_no_stall",    5'd0, 5'd0, 1, 1, 0, 5'd0, 1, 1, 0, 0, 1, C_NONE);
        tbl[5]  = mk("not_load",       5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0, 0, 1, C_NONE);
        tbl[6]  = mk("no_regwrite",    5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 1, 0, 0, 1, C_NONE);
        tbl[7]  = mk("rs1_unused",     5'd5, 5'd3, 0, 1, 0, 5'd5, 1, 1, 0, 0, 1, C_NONE);
        tbl[8]  = mk("branch_over_lu", 5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 1, 1, 0, 1, C_BR);
        tbl[9]  = mk("branch_only",    5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0, 1, 0, 1, C_BR);
        tbl[10] = mk("req_ready_lu",   5'd4, 5'd0, 1, 0, 0, 5'd4, 1, 1, 0, 1, 1, C_LU);
        tbl[11] = mk("idle",           5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, C_NONE);

        // Reset with hazard-provoking inputs applied: everything must stay low.
        rst_n = 1'b0;
        set_in(5'd5, 5'd5, 1, 1, 0, 5'd5, 1, 1, 1, 1, 0);
        #2;
        chk("reset_ctrl", ctrl_act, C_NONE);
        cyc();
        chk("reset_stall_count", hz.stall_count, 0);
        chk("reset_timeout", hz.mem_timeout, 0);
        rst_n = 1'b1;
        clear_in();
        #2;
        chk("after_reset_idle", ctrl_act, C_NONE);
        cyc();

        // Table of single-cycle decode cases from RUN.
        do_reset();
        exp_cnt = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            set_in(tbl[i].r1, tbl[i].r2, tbl[i].u1, tbl[i].u2, tbl[i].mw, tbl[i].wd,
                   tbl[i].rw, tbl[i].mr, tbl[i].br, tbl[i].req, tbl[i].rdy);
            #2;
            chk(tbl[i].name, ctrl_act, tbl[i].exp);
            if (tbl[i].exp[6]) exp_cnt = exp_cnt + 32'd1;
            cyc();
        end
        chk("table_stall_count", hz.stall_count, exp_cnt);

        // Load-use inserts exactly one bubble.
        do_reset();
        set_in(5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 1, 0, 0, 1);
        #2;
        chk("lu_seq_c1", ctrl_act, C_LU);
        cyc();
        set_in(5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        #2;
        chk("lu_seq_c2", ctrl_act, C_NONE);
        chk("lu_seq_count", hz.stall_count, 1);
        cyc();

        // Memory wait of 3 cycles, branch arriving in EX during the freeze.
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        #2;
        chk("wait_c1", ctrl_act, C_FRZ);
        cyc();
        hz.branch_taken_EX = 1'b1;
        #2;
        chk("wait_c2_branch_held", ctrl_act, C_FRZ);
        cyc();
        #2;
        chk("wait_c3", ctrl_act, C_FRZ);
        cyc();
        hz.mem_ready = 1'b1;
        #2;
        chk("wait_release_branch", ctrl_act, C_BR);
        chk("wait_count_at_release", hz.stall_count, 3);
        cyc();
        chk("wait_count_after", hz.stall_count, 3);
        hz.branch_taken_EX = 1'b0;
        #2;
        chk("ready_first_cycle", ctrl_act, C_NONE);
        cyc();
        // Still RUN: a low mem_ready without a request must not freeze.
        hz.mem_req_MEM = 1'b0;
        hz.mem_ready   = 1'b0;
        #2;
        chk("no_state_change", ctrl_act, C_NONE);
        cyc();

        // Timeout after 64 frozen cycles, sticky afterwards.
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 70; i++) begin
            cyc();
            if (i == 63) chk("timeout_not_yet", hz.mem_timeout, 0);
            if (i == 64) chk("timeout_set", hz.mem_timeout, 1);
        end
        #2;
        chk("timeout_still_frozen", ctrl_act, C_FRZ);
        hz.mem_ready = 1'b1;
        #2;
        chk("timeout_release", ctrl_act, C_NONE);
        cyc();
        hz.mem_req_MEM = 1'b0;
        #2;
        chk("timeout_sticky", hz.mem_timeout, 1);
        chk("timeout_count", hz.stall_count, 70);
        cyc();

        // Reset in the middle of a wait (timeout flag is set from above).
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        #2;
        chk("rst_mid_wait_outputs", ctrl_act, C_NONE);
        cyc();
        rst_n = 1'b1;
        hz.mem_req_MEM = 1'b0;
        hz.mem_ready   = 1'b0;
        #2;
        chk("rst_mid_wait_run", ctrl_act, C_NONE);
        chk("rst_mid_wait_count", hz.stall_count, 0);
        chk("rst_mid_wait_timeout", hz.mem_timeout, 0);
        cyc();

        // Randomized run against the reference model.
        do_reset();
        slow = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) slow = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rst_n = ($urandom_range(0, 399) != 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                   slow ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 2) != 0));
            #2;
            chk("rand_ctrl", ctrl_act, model_ctrl());
            chk("rand_stall_count", hz.stall_count, m_cnt);
            chk("rand_timeout", hz.mem_timeout, m_to);
            model_step();
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
